exu_iter: RTL and testbench

EXU_ITER -- requirements
Module: exu_iter

---
 rtl/exu_iter.sv | 149 ++++++++++++++
 tb/tb_exu_iter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exu_iter.sv
// Integer execution unit for RV OP/OP-IMM: single-cycle ALU ops, iterative shifter.
// Shifts move SHIFT_STEP bits per cycle; the first step is taken on the accept edge.
module exu_iter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [11:0]     in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // EXEC  | single-cycle ops resolve on the accept edge; never a resting state
    // SHIFT | shifting res_q, rem_q bits still to go
    // DONE  | result presented, held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

    localparam int          SH_W     = $clog2(XLEN);
    localparam logic [1:0]  K_SLL    = 2'd0;
    localparam logic [1:0]  K_SRL    = 2'd1;
    localparam logic [1:0]  K_SRA    = 2'd2;
    localparam logic [6:0]  OPC_IMM  = 7'b0010011;
    localparam logic [6:0]  OPC_REG  = 7'b0110011;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ill_q, ill_d;
    logic [SH_W-1:0]   rem_q, rem_d;
    logic [1:0]        kind_q, kind_d;

    logic              is_imm, is_reg, is_shift, is_sub, illegal;
    logic [XLEN-1:0]   op2, alu_res;
    logic [SH_W-1:0]   shamt, first_step, next_step;
    logic [1:0]        kind_in;

    function automatic logic [SH_W-1:0] step_of(input logic [SH_W-1:0] rem);
        if (int'(rem) > SHIFT_STEP)
            return SH_W'(SHIFT_STEP);
        return rem;
    endfunction

    // SRA relies on the accumulator MSB still holding the original sign bit.
    function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                                 input logic [1:0] kind,
                                                 input logic [SH_W-1:0] amt);
        case (kind)
            K_SLL:   return v << amt;
            K_SRL:   return v >> amt;
            default: return XLEN'($signed(v) >>> amt);
        endcase
    endfunction

    assign is_imm   = (in_op == OPC_IMM);
    assign is_reg   = (in_op == OPC_REG);
    assign op2      = is_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_src2;
    assign shamt    = op2[SH_W-1:0];
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign is_sub   = is_reg && in_funct7b5;
    assign illegal  = !(is_imm || is_reg) ||
                      (in_funct7b5 && !((in_funct3 == 3'b000 && is_reg) || in_funct3 == 3'b101));
    assign kind_in  = (in_funct3 == 3'b001) ? K_SLL : (in_funct7b5 ? K_SRA : K_SRL);
    assign first_step = step_of(shamt);
    assign next_step  = step_of(rem_q);

    always_comb begin
        alu_res = '0;
        case (in_funct3)
            3'b000:  alu_res = is_sub ? in_src1 - op2 : in_src1 + op2;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_src1) < $signed(op2)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, in_src1 < op2};
            3'b100:  alu_res = in_src1 ^ op2;
            3'b110:  alu_res = in_src1 | op2;
            3'b111:  alu_res = in_src1 & op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ill_d   = ill_q;
        rem_d   = rem_q;
        kind_d  = kind_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                    if (illegal) begin
                        res_d = '0;
                        ill_d = 1'b1;
                    end else if (is_shift) begin
                        kind_d = kind_in;
                        res_d  = shift_by(in_src1, kind_in, first_step);
                        rem_d  = shamt - first_step;
                        if (shamt != first_step)
                            state_d = S_SHIFT;
                    end else begin
                        res_d = alu_res;
                    end
                end
            end
            S_SHIFT: begin
                res_d = shift_by(res_q, kind_q, next_step);
                rem_d = rem_q - next_step;
                if (rem_q == next_step)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            ill_q   <= 1'b0;
            rem_q   <= '0;
            kind_q  <= K_SLL;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
            rem_q   <= rem_d;
            kind_q  <= kind_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = res_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_exu_iter.sv
// Scoreboard bench for exu_iter: directed corner cases plus random ops
// checked against a one-shot arithmetic reference model.
module tb_exu_iter;
    localparam int XLEN = 32;
    localparam int STEP = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      in_op = '0;
    logic [2:0]      in_funct3 = '0;
    logic            in_funct7b5 = 1'b0;
    logic [XLEN-1:0] in_src1 = '0;
    logic [XLEN-1:0] in_src2 = '0;
    logic [11:0]     in_imm = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            out_illegal;

    exu_iter #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: straight from the instruction semantics.
    task automatic ref_model(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                             input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] imm,
                             output logic [31:0] res, output logic ill, output int lat);
        logic [31:0] b;
        int sh;
        res = 0; ill = 0; lat = 1;
        if (op != 7'h13 && op != 7'h33) begin ill = 1; return; end
        if (b5 && !((f3 == 0 && op == 7'h33) || f3 == 5)) begin ill = 1; return; end
        b  = (op == 7'h13) ? {{20{imm[11]}}, imm} : s2;
        sh = int'(b % 32);
        case (f3)
            3'd0: res = (op == 7'h33 && b5) ? s1 - b : s1 + b;
            3'd2: res = ($signed(s1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (s1 < b) ? 32'd1 : 32'd0;
            3'd4: res = s1 ^ b;
            3'd6: res = s1 | b;
            3'd7: res = s1 & b;
            3'd1: res = s1 << sh;
            default: res = b5 ? 32'($signed(s1) >>> sh) : s1 >> sh;
        endcase
        if (f3 == 1 || f3 == 5) lat = (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] imm);
        exp_t e;
        int n = 0;
        @(negedge clk);
        in_op = op; in_funct3 = f3; in_funct7b5 = b5;
        in_src1 = s1; in_src2 = s2; in_imm = imm; in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        ref_model(op, f3, b5, s1, s2, imm, e.res, e.ill, e.lat);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 7'($urandom); in_funct3 = 3'($urandom); in_funct7b5 = 1'($urandom);
        in_src1 = $urandom; in_src2 = $urandom; in_imm = 12'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: latency, hold-while-stalled, result compare, return to idle.
    bit          seen = 0, stall = 0, hs = 0;
    logic [31:0] prev_res;
    logic        prev_ill;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0; stall = 0; hs = 0;
        end else begin
            if (hs) begin
                chk("idle_ready", 64'(in_ready), 64'd1);
                chk("idle_valid", 64'(out_valid), 64'd0);
            end
            hs = 0;
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'(out_result), 64'(prev_res));
                chk("hold_illegal", 64'(out_illegal), 64'(prev_ill));
            end
            stall = 0;
            if (out_valid) begin
                chk("busy_ready", 64'(in_ready), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        chk("result", 64'(out_result), 64'(e.res));
                        chk("illegal", 64'(out_illegal), 64'(e.ill));
                        seen = 0;
                        hs = 1;
                    end else begin
                        stall = 1;
                        prev_res = out_result;
                        prev_ill = out_illegal;
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] op;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;

        issue(7'h13, 3'b000, 1'b0, 32'h5, 32'h0, 12'hFFF);
        issue(7'h13, 3'b101, 1'b1, 32'h80000000, 32'h0, 12'h41F);
        issue(7'h13, 3'b101, 1'b1, 32'h80000000, 32'h0, 12'h400);
        issue(7'h33, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1, 12'h0);
        issue(7'h33, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1, 12'h0);
        issue(7'h33, 3'b001, 1'b1, 32'h12345678, 32'h3, 12'h0);
        issue(7'h03, 3'b000, 1'b0, 32'h12345678, 32'h3, 12'h0);
        drain();

        // Consumer stalls 5+ cycles on a SUB result.
        @(posedge clk); #1 out_ready = 1'b0;
        issue(7'h33, 3'b000, 1'b1, 32'h3, 32'h5, 12'h0);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a 20-bit SLL.
        issue(7'h33, 3'b001, 1'b0, 32'h1, 32'd20, 12'h0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_result", 64'(out_result), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(7'h33, 3'b000, 1'b0, 32'h1, 32'h2, 12'h0);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       op = 7'($urandom);
                1, 2, 3, 4: op = 7'h13;
                default: op = 7'h33;
            endcase
            issue(op, 3'($urandom), ($urandom_range(0, 3) == 0), $urandom, $urandom, 12'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
